// File: rtl/inst_align_pkg.sv
// Shared types and constants for the RV64C fetch alignment stage.
// Contents: FSM state enum, buffer slot struct, line/halfword constants,
// and the compressed-instruction predicate.
package inst_align_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} fsm_e;

  localparam int unsigned LINE_SHIFT = 3;
  localparam int unsigned LINE_DW    = 64;
  localparam int unsigned HW_W       = 16;
  localparam int unsigned INST_W     = 32;
  localparam logic [1:0]  C_MASK     = 2'b11;

  // One 8-byte buffer slot: fetched line data plus its valid flag.
  typedef struct packed {
    logic [LINE_DW-1:0] data;
    logic               v;
  } slot_t;

  // A halfword starts a 16-bit instruction unless its low two bits are 11.
  function automatic logic is_compressed(input logic [HW_W-1:0] hw);
    return (hw[1:0] & C_MASK) != C_MASK;
  endfunction

endpackage

// File: rtl/inst_align_if.sv
// Bundle between the alignment stage, its consumer and instruction memory.
// Ports: pc (consumer address), inst/inst_valid/inst_comp (aligned
// instruction), request/mem_req/mem_addr (fetch), mem_ready/mem_data (reply).
// master: the alignment stage view; slave: the consumer/memory view.
interface inst_align_if #(
  parameter int unsigned PC_W = 64
);
  logic [PC_W-1:0] pc;
  logic            inst_valid;
  logic            inst_comp;
  logic [31:0]     inst;
  logic            request;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ready;
  logic [63:0]     mem_data;

  modport master (
    input  pc, mem_ready, mem_data,
    output inst_valid, inst_comp, inst, request, mem_req, mem_addr
  );

  modport slave (
    output pc, mem_ready, mem_data,
    input  inst_valid, inst_comp, inst, request, mem_req, mem_addr
  );
endinterface

// File: rtl/inst_extract.sv
// Combinational extraction of the instruction at halfword h of the current
// line, pulling the upper half from the next line when a 32-bit instruction
// starts in the last halfword.
// Ports: h (pc[2:1]), cur_data/cur_v, nxt_lo/nxt_v (low halfword of next
// line), line_hit (pc is halfword aligned and in the current line)
// -> inst, inst_valid, inst_comp.
module inst_extract
  import inst_align_pkg::*;
(
  input  logic [1:0]         h,
  input  logic [LINE_DW-1:0] cur_data,
  input  logic               cur_v,
  input  logic [HW_W-1:0]    nxt_lo,
  input  logic               nxt_v,
  input  logic               line_hit,
  output logic [INST_W-1:0]  inst,
  output logic               inst_valid,
  output logic               inst_comp
);

  logic [HW_W-1:0]   hw0;
  logic [INST_W-1:0] raw;
  logic              comp;

  // Select the first halfword and the 32-bit window starting there.
  always_comb begin
    hw0        = '0;
    raw        = '0;
    comp       = 1'b0;
    inst       = '0;
    inst_valid = 1'b0;
    inst_comp  = 1'b0;
    case (h)
      2'd0:    begin hw0 = cur_data[15:0];  raw = cur_data[31:0];          end
      2'd1:    begin hw0 = cur_data[31:16]; raw = cur_data[47:16];         end
      2'd2:    begin hw0 = cur_data[47:32]; raw = cur_data[63:32];         end
      default: begin hw0 = cur_data[63:48]; raw = {nxt_lo, cur_data[63:48]}; end
    endcase
    comp       = is_compressed(hw0);
    // Only a straddling 32-bit instruction needs the next line.
    inst_valid = line_hit && cur_v && (comp || (h != 2'd3) || nxt_v);
    inst_comp  = inst_valid && comp;
    if (inst_valid) begin
      inst = comp ? {16'h0, hw0} : raw;
    end
  end

endmodule

// File: rtl/inst_align.sv
// Fetch-side alignment stage: keeps a two-line buffer (cur = line B,
// nxt = line B+1) filled from memory and presents the instruction at pc.
// Ports: clk, rst_n (synchronous, active-low), bus (inst_align_if.master):
// pc in; inst/inst_valid/inst_comp out (combinational); request/mem_req/
// mem_addr out (registered); mem_ready/mem_data in.
module inst_align
  import inst_align_pkg::*;
#(
  parameter int unsigned PC_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_align_if.master bus
);

  localparam int unsigned LINE_W = PC_W - LINE_SHIFT;

  fsm_e              state, state_n;
  logic [LINE_W-1:0] base, base_n;
  logic [LINE_W-1:0] req_line, req_line_n;
  slot_t             cur, cur_n, nxt, nxt_n;
  logic              mem_req, mem_req_n;
  logic [PC_W-1:0]   mem_addr, mem_addr_n;

  logic [LINE_W-1:0] pc_line;
  logic [LINE_W-1:0] issue_line;
  logic              line_hit, line_next, do_issue, pc_ok;

  // Next-state: line tracking, fill, then issue against the updated buffer.
  always_comb begin
    state_n    = state;
    base_n     = base;
    cur_n      = cur;
    nxt_n      = nxt;
    req_line_n = req_line;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    issue_line = '0;
    do_issue   = 1'b0;

    pc_line   = bus.pc[PC_W-1:LINE_SHIFT];
    line_hit  = (pc_line == base);
    line_next = (pc_line == base + LINE_W'(1));

    if (!line_hit) begin
      if (line_next && cur.v) begin
        base_n  = base + LINE_W'(1);
        cur_n   = nxt;
        nxt_n.v = 1'b0;
      end else begin
        base_n  = pc_line;
        cur_n.v = 1'b0;
        nxt_n.v = 1'b0;
        // An outstanding fetch still useful to the new window stays BUSY.
        if (state == BUSY && req_line != pc_line &&
            req_line != pc_line + LINE_W'(1)) begin
          state_n = DRAIN;
        end
      end
    end

    if (bus.mem_ready && state != IDLE) begin
      mem_req_n = 1'b0;
      state_n   = IDLE;
      if (state == BUSY) begin
        if (req_line == base_n) begin
          cur_n = '{data: bus.mem_data, v: 1'b1};
        end else if (req_line == base_n + LINE_W'(1)) begin
          nxt_n = '{data: bus.mem_data, v: 1'b1};
        end
      end
    end

    // A new fetch may only start once the previous one has completed.
    if (state == IDLE || bus.mem_ready) begin
      if (!cur_n.v) begin
        do_issue   = 1'b1;
        issue_line = base_n;
      end else if (!nxt_n.v) begin
        do_issue   = 1'b1;
        issue_line = base_n + LINE_W'(1);
      end
    end

    if (do_issue) begin
      state_n    = BUSY;
      req_line_n = issue_line;
      mem_req_n  = 1'b1;
      mem_addr_n = {issue_line, {LINE_SHIFT{1'b0}}};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      cur      <= '0;
      nxt      <= '0;
      req_line <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_n;
      base     <= base_n;
      cur      <= cur_n;
      nxt      <= nxt_n;
      req_line <= req_line_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
    end
  end

  assign pc_ok        = line_hit && !bus.pc[0];
  assign bus.mem_req  = mem_req;
  assign bus.request  = mem_req;
  assign bus.mem_addr = mem_addr;

  inst_extract u_extract (
    .h          (bus.pc[2:1]),
    .cur_data   (cur.data),
    .cur_v      (cur.v),
    .nxt_lo     (nxt.data[HW_W-1:0]),
    .nxt_v      (nxt.v),
    .line_hit   (pc_ok),
    .inst       (bus.inst),
    .inst_valid (bus.inst_valid),
    .inst_comp  (bus.inst_comp)
  );

endmodule

// File: tb/tb_inst_align.sv
// Scoreboard bench for inst_align: a consumer driver pushes expected
// instructions/fetch addresses; a negedge process models memory and checks.
module tb_inst_align;

  localparam int unsigned PC_W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_align_if #(.PC_W(PC_W)) bus ();

  inst_align #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] mem [logic [63:0]];
  logic [63:0] exp_pc_q [$];
  logic [31:0] exp_inst_q [$];
  logic        exp_comp_q [$];
  logic [63:0] exp_addr_q [$];
  int          lat_q [$];
  string       probe_name_q [$];
  logic [63:0] probe_got_q [$];
  logic [63:0] probe_exp_q [$];
  logic        taking = 1'b0;

  logic        pend = 1'b0;
  int          cnt = 0;
  int          cur_lat = 1;
  logic [63:0] req_addr = '0;

  // Memory model, instruction monitor and probe checker.
  always @(negedge clk) begin
    logic [63:0] e_pc, e_addr, pg, pe;
    logic [31:0] e_inst;
    logic        e_comp;
    string       pn;
    if (!rst_n) begin
      pend = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_data = '0;
    end else begin
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        pend = 1'b0;
      end
      if (pend) begin
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== req_addr) begin
          failures++;
          $display("FAIL req_stable got req=%0b addr=%h need req=1 addr=%h",
                   bus.mem_req, bus.mem_addr, req_addr);
        end
      end else if (bus.mem_req === 1'b1) begin
        pend = 1'b1;
        cnt = 0;
        req_addr = bus.mem_addr;
        cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL mem_addr got unexpected request addr=%h need none", req_addr);
        end else begin
          e_addr = exp_addr_q.pop_front();
          if (req_addr !== e_addr) begin
            failures++;
            $display("FAIL mem_addr got %h need %h", req_addr, e_addr);
          end
        end
      end
      if (pend) begin
        cnt++;
        if (cnt >= cur_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_data = mem.exists(req_addr) ? mem[req_addr] : 64'h0;
        end
      end
    end

    checks++;
    if (bus.inst_valid !== 1'b1 && (bus.inst !== 32'h0 || bus.inst_comp !== 1'b0)) begin
      failures++;
      $display("FAIL idle_out got inst=%h comp=%0b need inst=0 comp=0", bus.inst, bus.inst_comp);
    end
    if (bus.inst_valid === 1'b1 && taking) begin
      checks++;
      if (exp_inst_q.size() == 0) begin
        failures++;
        $display("FAIL inst got unexpected pc=%h inst=%h need none", bus.pc, bus.inst);
      end else begin
        e_pc = exp_pc_q.pop_front();
        e_inst = exp_inst_q.pop_front();
        e_comp = exp_comp_q.pop_front();
        if (bus.pc !== e_pc || bus.inst !== e_inst || bus.inst_comp !== e_comp) begin
          failures++;
          $display("FAIL inst got pc=%h inst=%h comp=%0b need pc=%h inst=%h comp=%0b",
                   bus.pc, bus.inst, bus.inst_comp, e_pc, e_inst, e_comp);
        end
      end
    end

    while (probe_name_q.size() > 0) begin
      pn = probe_name_q.pop_front();
      pg = probe_got_q.pop_front();
      pe = probe_exp_q.pop_front();
      checks++;
      if (pg !== pe) begin
        failures++;
        $display("FAIL %s got %0h need %0h", pn, pg, pe);
      end
    end
  end

  task automatic probe(input string name, input logic [63:0] got, input logic [63:0] exp);
    probe_name_q.push_back(name);
    probe_got_q.push_back(got);
    probe_exp_q.push_back(exp);
  endtask

  task automatic do_reset(input logic [63:0] start_pc);
    rst_n = 1'b0;
    bus.pc = start_pc;
    taking = 1'b0;
    exp_addr_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present pc until the DUT shows a valid instruction, then advance.
  task automatic consume(input logic [63:0] p, input logic [31:0] ei,
                         input logic ec, input int exp_stall);
    int waited = 0;
    exp_pc_q.push_back(p);
    exp_inst_q.push_back(ei);
    exp_comp_q.push_back(ec);
    bus.pc = p;
    taking = 1'b1;
    @(negedge clk);
    while (bus.inst_valid !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (bus.inst_valid !== 1'b1) begin
      probe("inst_timeout", 64'(bus.inst_valid), 64'h1);
      exp_pc_q.delete();
      exp_inst_q.delete();
      exp_comp_q.delete();
    end else if (exp_stall >= 0) begin
      probe("stall_cycles", 64'(waited), 64'(exp_stall));
    end
    @(posedge clk);
    #1 taking = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    repeat (n) @(posedge clk);
    #1 probe("pending_addr", 64'(exp_addr_q.size()), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout need finish");
    $fatal(1);
  end

  initial begin
    // Basic: 1-cycle memory, first valid in cycle 2.
    mem[64'h0] = 64'h4505_4501_00a0_0093;
    mem[64'h8] = 64'h0000_0000_0000_0001;
    do_reset(64'h0);
    exp_addr_q.push_back(64'h0);
    exp_addr_q.push_back(64'h8);
    consume(64'h0, 32'h00a0_0093, 1'b0, 2);
    consume(64'h4, 32'h0000_4501, 1'b1, 0);
    consume(64'h6, 32'h0000_4505, 1'b1, 0);
    wait_idle(8);

    // Straddle: next line delayed 4 cycles.
    mem[64'h0]  = 64'h0513_0001_0001_0001;
    mem[64'h8]  = 64'h0000_0000_4501_0000;
    mem[64'h10] = 64'h0;
    do_reset(64'h0);
    lat_q.push_back(1);
    lat_q.push_back(4);
    exp_addr_q.push_back(64'h0);
    exp_addr_q.push_back(64'h8);
    exp_addr_q.push_back(64'h10);
    consume(64'h0, 32'h0000_0001, 1'b1, 2);
    consume(64'h2, 32'h0000_0001, 1'b1, 0);
    consume(64'h4, 32'h0000_0001, 1'b1, 0);
    consume(64'h6, 32'h0000_0513, 1'b0, 1);
    consume(64'hA, 32'h0000_4501, 1'b1, 1);
    wait_idle(8);

    // Shift/prefetch then flush while the 0x10 fetch is outstanding.
    mem[64'h0]   = 64'h00b0_0113_00a0_0093;
    mem[64'h8]   = 64'h00d0_0213_00c0_0193;
    mem[64'h10]  = 64'h00f0_0313_00e0_0293;
    mem[64'h100] = 64'h0000_0000_0000_4505;
    mem[64'h108] = 64'h0;
    do_reset(64'h0);
    lat_q.push_back(1);
    lat_q.push_back(1);
    lat_q.push_back(4);
    exp_addr_q.push_back(64'h0);
    exp_addr_q.push_back(64'h8);
    exp_addr_q.push_back(64'h10);
    exp_addr_q.push_back(64'h100);
    exp_addr_q.push_back(64'h108);
    consume(64'h0,   32'h00a0_0093, 1'b0, 2);
    consume(64'h4,   32'h00b0_0113, 1'b0, 0);
    consume(64'h8,   32'h00c0_0193, 1'b0, 1);
    consume(64'hC,   32'h00d0_0213, 1'b0, 0);
    consume(64'h100, 32'h0000_4505, 1'b1, 3);
    wait_idle(8);

    // Synchronous reset in the middle of a 5-cycle request.
    mem[64'h40] = 64'h1;
    mem[64'h48] = 64'h0000_0000_00b0_0113;
    mem[64'h50] = 64'h0;
    do_reset(64'h40);
    lat_q.push_back(5);
    exp_addr_q.push_back(64'h40);
    exp_addr_q.push_back(64'h48);
    exp_addr_q.push_back(64'h50);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    probe("glitch_mem_req", 64'(bus.mem_req), 64'h1);
    probe("glitch_mem_addr", bus.mem_addr, 64'h40);
    probe("glitch_inst_valid", 64'(bus.inst_valid), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.pc = 64'h48;
    @(posedge clk);
    @(negedge clk);
    probe("rst_mem_req", 64'(bus.mem_req), 64'h0);
    probe("rst_request", 64'(bus.request), 64'h0);
    probe("rst_mem_addr", bus.mem_addr, 64'h0);
    probe("rst_inst_valid", 64'(bus.inst_valid), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    consume(64'h48, 32'h00b0_0113, 1'b0, 2);
    wait_idle(8);

    // Slow memory: 5-cycle latency on every fetch.
    mem[64'h0] = 64'h4505_4501_00a0_0093;
    mem[64'h8] = 64'h0000_0000_0000_0001;
    do_reset(64'h0);
    lat_q.push_back(5);
    lat_q.push_back(5);
    exp_addr_q.push_back(64'h0);
    exp_addr_q.push_back(64'h8);
    consume(64'h0, 32'h00a0_0093, 1'b0, 6);
    consume(64'h4, 32'h0000_4501, 1'b1, 0);
    consume(64'h6, 32'h0000_4505, 1'b1, 0);
    wait_idle(14);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
